// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: PC/step/stall/flush control, the byte-serial loader, and the IF/ID outputs.
// The master side drives the i_* signals. The slave side (the fetch stage) drives the o_* signals.
interface instruction_fetch_if #(
    parameter int NB     = 32,
    parameter int ADDR_W = 6
);
    logic              i_step;
    logic [NB-1:0]     i_pc;
    logic              i_stall;
    logic              i_flush;
    logic              i_load_valid;
    logic [7:0]        i_load_byte;
    logic              i_load_clear;
    logic [ADDR_W:0]   o_load_count;
    logic              o_mem_full;
    logic [NB-1:0]     o_instruction;
    logic [NB-1:0]     o_pc4;
    logic              o_halt;

    modport master (
        output i_step, i_pc, i_stall, i_flush, i_load_valid, i_load_byte, i_load_clear,
        input  o_load_count, o_mem_full, o_instruction, o_pc4, o_halt
    );

    modport slave (
        input  i_step, i_pc, i_stall, i_flush, i_load_valid, i_load_byte, i_load_clear,
        output o_load_count, o_mem_full, o_instruction, o_pc4, o_halt
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: byte-loaded instruction memory, combinational read, and the IF/ID register with halt detect.
// Latency: the PC presented in cycle N appears on IF/ID after the edge that ends cycle N. A loaded word is readable one cycle after it is written.
// Backpressure: i_step=0 or i_stall holds IF/ID. i_flush inserts a NOP. Loader bytes are dropped once memory is full.
module instruction_fetch #(
    parameter int NB        = 32,
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    instruction_fetch_if.slave    bus
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [NB-1:0]   HALT_WORD  = '1;
    localparam logic [NB-1:0]   PC_INC     = NB'(4);

    typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, BYTE3} load_state_t;

    logic [NB-1:0]     mem [MEM_DEPTH];

    load_state_t       state, state_nxt;
    logic [23:0]       asm_q, asm_nxt;
    logic [ADDR_W:0]   wr_ptr, wr_ptr_nxt;
    logic              wr_en;
    logic [NB-1:0]     wr_word;
    logic              mem_full;

    logic [ADDR_W-1:0] rd_idx;
    logic [NB-1:0]     rd_word;
    logic [NB-1:0]     instr_q, pc4_q;
    logic              halt_q;

    assign mem_full = (wr_ptr == FULL_COUNT);

    always_comb begin
        state_nxt  = state;
        asm_nxt    = asm_q;
        wr_ptr_nxt = wr_ptr;
        wr_en      = 1'b0;
        wr_word    = {asm_q, bus.i_load_byte};
        if (bus.i_load_clear) begin
            state_nxt  = BYTE0;
            wr_ptr_nxt = '0;
        end else if (bus.i_load_valid && !mem_full) begin
            case (state)
                BYTE0: begin asm_nxt = {asm_q[15:0], bus.i_load_byte}; state_nxt = BYTE1; end
                BYTE1: begin asm_nxt = {asm_q[15:0], bus.i_load_byte}; state_nxt = BYTE2; end
                BYTE2: begin asm_nxt = {asm_q[15:0], bus.i_load_byte}; state_nxt = BYTE3; end
                BYTE3: begin
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr + 1'b1;
                    state_nxt  = BYTE0;
                end
                default: state_nxt = BYTE0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= BYTE0;
            asm_q  <= '0;
            wr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            asm_q  <= asm_nxt;
            wr_ptr <= wr_ptr_nxt;
        end
    end

    // Memory contents deliberately survive reset so a loaded program can be re-run.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_reset)
            mem[wr_ptr[ADDR_W-1:0]] <= wr_word;
    end

    assign rd_idx  = bus.i_pc[ADDR_W+1:2];
    assign rd_word = mem[rd_idx];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            instr_q <= '0;
            pc4_q   <= '0;
            halt_q  <= 1'b0;
        end else if (bus.i_step) begin
            if (bus.i_flush) begin
                instr_q <= '0;
                pc4_q   <= bus.i_pc + PC_INC;
                halt_q  <= 1'b0;
            end else if (!bus.i_stall) begin
                instr_q <= rd_word;
                pc4_q   <= bus.i_pc + PC_INC;
                halt_q  <= (rd_word == HALT_WORD);
            end
        end
    end

    assign bus.o_instruction = instr_q;
    assign bus.o_pc4         = pc4_q;
    assign bus.o_halt        = halt_q;
    assign bus.o_load_count  = wr_ptr;
    assign bus.o_mem_full    = mem_full;
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the pipelined MIPS core, directly downstream of the PC register. It holds the instruction memory, assembles program words from the debug loader's byte stream, reads the word addressed by the incoming PC, and latches it with PC+4 into the IF/ID pipeline register consumed by decode. It honours debug stepping, hazard stalls and branch flushes, and flags the halt opcode.

## Interface
- NB, 32, data/address width
- MEM_DEPTH, 64, instruction memory depth in words, power of two
- ADDR_W, 6, word-index width, log2(MEM_DEPTH)

Ports:
- i_clk  in  1  system clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_step  in  1  pipeline advance enable (debug step / run)
- i_pc  in  NB  current PC from the PC register
- i_stall  in  1  hold IF/ID contents (hazard unit)
- i_flush  in  1  replace latched instruction with NOP (taken branch/jump)
- i_load_valid  in  1  one loader byte present this cycle
- i_load_byte  in  8  loader byte, big-endian order (first byte = bits 31:24)
- i_load_clear  in  1  restart loading at word 0
- o_load_count  out  ADDR_W+1  number of complete words written
- o_mem_full  out  1  high when o_load_count == MEM_DEPTH
- o_instruction  out  NB  IF/ID instruction
- o_pc4  out  NB  IF/ID PC+4
- o_halt  out  1  IF/ID instruction equals 32'hFFFFFFFF

## Operation
- Read index = i_pc[ADDR_W+1:2]; bits [1:0] and above ADDR_W+1 ignored (index wraps modulo MEM_DEPTH). Read is combinational from memory into the IF/ID register.
- IF/ID update at edge, priority order: i_reset > i_flush (with i_step) > i_stall > i_step.
  - i_reset: o_instruction=0, o_pc4=0, o_halt=0.
  - i_step=0: hold everything (flush and stall ignored).
  - i_step=1, i_flush=1: o_instruction=0 (NOP), o_pc4=i_pc+4, o_halt=0; flush wins over stall.
  - i_step=1, i_stall=1, i_flush=0: hold.
  - i_step=1 otherwise: o_instruction=mem[index], o_pc4=i_pc+4 (mod 2^NB), o_halt=(mem[index]==32'hFFFFFFFF).
- Loader FSM, states BYTE0..BYTE3 plus word pointer wr_ptr (ADDR_W+1 bits):
  - Each i_load_valid advances BYTEn -> BYTEn+1, shifting byte into assembly register.
  - In BYTE3 with i_load_valid: write assembled word to mem[wr_ptr], wr_ptr+1, return to BYTE0.
  - When o_mem_full=1, bytes are dropped; FSM and pointer hold.
  - i_load_clear: FSM -> BYTE0, wr_ptr -> 0, partial word discarded; takes priority over a same-cycle byte. Memory contents kept.
  - Loader operates independently of i_step/i_stall.
- i_reset: FSM -> BYTE0, wr_ptr -> 0; memory contents NOT cleared.
- o_load_count = wr_ptr; o_mem_full registered-equivalent (derived from wr_ptr).

## Timing
- Fetch latency: i_pc presented in cycle N -> o_instruction/o_pc4/o_halt valid after edge ending cycle N.
- Write on the edge completing byte 3; word readable by fetch from the following cycle. Same-edge read of the address being written returns the old contents.
- o_load_count increments on the edge that writes the word.
- Reset mid-word: partial bytes lost, next byte is BYTE0 of word 0.
- All outputs 0 after reset.

## Test plan
- Reset, then load bytes 20,08,00,05 -> after 4th byte o_load_count=1, mem[0]=32'h20080005; i_pc=0, i_step=1 -> next edge o_instruction=32'h20080005, o_pc4=4.
- Load 3 words, run i_pc 0,4,8 with i_step=1 -> o_pc4 sequence 4,8,C and matching words; i_step=0 one cycle -> outputs hold.
- i_stall=1 with i_pc=8 -> outputs keep word at 4; i_stall=1 and i_flush=1 together -> o_instruction=0, o_pc4=C.
- Load 32'hFFFFFFFF at word 3, fetch i_pc=C -> o_halt=1; next fetch of a normal word -> o_halt=0.
- Send 2 bytes, assert i_load_clear, send 4 bytes AA,BB,CC,DD -> mem[0]=32'hAABBCCDD, o_load_count=1.
- Load MEM_DEPTH words -> o_mem_full=1, o_load_count=64; extra 4 bytes leave mem[0] unchanged; i_pc=32'h100 fetches mem[0] (wrap).
